// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-way intersection controller with a pedestrian all-red phase.
//   A prescaler turns the clock into 1 s ticks; a seconds counter times
//   each phase. Both restart on every state entry, so a phase of D seconds
//   lasts exactly D*TICKS_PER_SEC cycles.
// Ports
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   walk       : pedestrian request (level, latched into walk_req)
//   sensor     : side/main vehicle sensor (level, latched into sens_seen)
//   main_light : {red,yellow,green} main street, one-hot, registered
//   side_light : {red,yellow,green} side street, one-hot, registered
//   walk_light : pedestrian lamp, high only in WALK
//   state      : current state code
module traffic_light_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int T_BASE        = 6,
  parameter int T_EXT         = 3,
  parameter int T_YEL         = 2,
  parameter int T_WALK        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       walk,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_EXT = 3'd1,
    MAIN_YEL = 3'd2,
    WALK     = 3'd3,
    SIDE_GRN = 3'd4,
    SIDE_EXT = 3'd5,
    SIDE_YEL = 3'd6
  } state_t;

  localparam int TW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DM1   = (T_BASE > T_EXT) ? T_BASE : T_EXT;
  localparam int DM2   = (T_YEL > T_WALK) ? T_YEL : T_WALK;
  localparam int DMAX  = (DM1 > DM2) ? DM1 : DM2;
  // seconds counter only ever holds 0..DMAX-1
  localparam int SW    = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam bit EXT_EN = (T_EXT > 0);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] LAST_BASE = SW'(T_BASE - 1);
  localparam logic [SW-1:0] LAST_EXT  = SW'(EXT_EN ? T_EXT - 1 : 0);
  localparam logic [SW-1:0] LAST_YEL  = SW'(T_YEL - 1);
  localparam logic [SW-1:0] LAST_WALK = SW'(T_WALK - 1);

  state_t          cur, nxt;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   sec_cnt, last_sec;
  logic            walk_req, sens_seen;
  logic            tick, done, restart;

  // {main, side, walk_light}
  function automatic logic [6:0] lamp(input state_t s);
    case (s)
      MAIN_GRN, MAIN_EXT: lamp = 7'b001_100_0;
      MAIN_YEL:           lamp = 7'b010_100_0;
      WALK:               lamp = 7'b100_100_1;
      SIDE_GRN, SIDE_EXT: lamp = 7'b100_001_0;
      SIDE_YEL:           lamp = 7'b100_010_0;
      default:            lamp = 7'b001_100_0;
    endcase
  endfunction

  always_comb begin
    tick = (tick_cnt == TICK_LAST);
    last_sec = LAST_BASE;
    case (cur)
      MAIN_EXT, SIDE_EXT: last_sec = LAST_EXT;
      MAIN_YEL, SIDE_YEL: last_sec = LAST_YEL;
      WALK:               last_sec = LAST_WALK;
      default:            last_sec = LAST_BASE;
    endcase
    done = tick && (sec_cnt == last_sec);
    nxt = cur;
    case (cur)
      // sensor/walk in the final cycle still count: OR the live input in
      MAIN_GRN: if (done) nxt = ((sens_seen || sensor) && EXT_EN) ? MAIN_EXT : MAIN_YEL;
      MAIN_EXT: if (done) nxt = MAIN_YEL;
      MAIN_YEL: if (done) nxt = (walk_req || walk) ? WALK : SIDE_GRN;
      WALK:     if (done) nxt = SIDE_GRN;
      SIDE_GRN: if (done) nxt = ((sens_seen || sensor) && EXT_EN) ? SIDE_EXT : SIDE_YEL;
      SIDE_EXT: if (done) nxt = SIDE_YEL;
      SIDE_YEL: if (done) nxt = MAIN_GRN;
      default:  nxt = MAIN_GRN;   // unused code 7
    endcase
    // no state loops to itself, so any change of state is an entry
    restart = (nxt != cur);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur        <= MAIN_GRN;
      tick_cnt   <= '0;
      sec_cnt    <= '0;
      walk_req   <= 1'b0;
      sens_seen  <= 1'b0;
      main_light <= 3'b001;
      side_light <= 3'b100;
      walk_light <= 1'b0;
    end else begin
      cur <= nxt;
      {main_light, side_light, walk_light} <= lamp(nxt);

      if (restart) begin
        tick_cnt <= '0;
        sec_cnt  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) sec_cnt <= sec_cnt + SW'(1);
      end

      if (restart && (nxt == MAIN_GRN || nxt == SIDE_GRN))
        sens_seen <= 1'b0;
      else if ((cur == MAIN_GRN || cur == SIDE_GRN) && sensor)
        sens_seen <= 1'b1;

      // entering WALK consumes the request, including a walk seen this edge
      if (restart && nxt == WALK)
        walk_req <= 1'b0;
      else if (cur != WALK && walk)
        walk_req <= 1'b1;
    end
  end

  assign state = cur;

endmodule
